// File: rtl/hybrid_chaotic_encryption_pkg.sv
// Shared types and constants for the hybrid chaotic byte-stream cipher.
package hybrid_chaotic_encryption_pkg;

    // Cipher control states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } state_t;

    // Key field positions (each field is one byte, except the precision bit)
    localparam int unsigned KEY_PREC_BIT  = 32;
    localparam int unsigned KEY_K_LSB     = 24;
    localparam int unsigned KEY_Y0_LSB    = 16;
    localparam int unsigned KEY_ALPHA_LSB = 8;
    localparam int unsigned KEY_MU_LSB    = 0;

    // mu gets integer part 3, y0 gets a nonzero low nibble, the map never sticks at 0
    localparam logic [1:0]  MU_INT_PREFIX = 2'b11;
    localparam logic [3:0]  Y0_PAD        = 4'b1000;
    localparam logic [11:0] ZERO_FIX      = 12'h010;

endpackage

// File: rtl/hybrid_chaotic_encryption_logistic_step.sv
// One iteration of the fixed-point logistic map: f(x) = mu * x * (1 - x).
// x is Q0.12, mu is Q2.10; the result is forced nonzero.
module logistic_step
    import hybrid_chaotic_encryption_pkg::*;
#(
    parameter int DATA_WIDTH = 12
) (
    input  logic [DATA_WIDTH-1:0] x,
    input  logic [DATA_WIDTH-1:0] mu,
    input  logic                  prec,
    output logic [DATA_WIDTH-1:0] fx
);

    localparam int PW = 2 * DATA_WIDTH + 1;

    logic [DATA_WIDTH:0]   comp;
    logic [PW-1:0]         t_prod;
    logic [DATA_WIDTH-1:0] t;
    logic [2*DATA_WIDTH-1:0] n_prod;
    logic [DATA_WIDTH-1:0] n;
    logic                  unused_bits;

    // Map arithmetic: t = x*(1-x) in Q0.12, then n = mu*t rescaled to Q0.12
    always_comb begin
        comp   = {1'b1, {DATA_WIDTH{1'b0}}} - {1'b0, x};
        t_prod = {{(DATA_WIDTH+1){1'b0}}, x} * {{DATA_WIDTH{1'b0}}, comp};
        t      = t_prod[2*DATA_WIDTH-1:DATA_WIDTH];
        n_prod = {{DATA_WIDTH{1'b0}}, mu} * {{DATA_WIDTH{1'b0}}, t};
        n      = n_prod[2*DATA_WIDTH-3:DATA_WIDTH-2];
        if (!prec) begin
            n[3:0] = 4'b0000;
        end
        if (n == '0) begin
            n = ZERO_FIX;
        end
        fx = n;
    end

    // Truncated product bits are intentionally discarded
    always_comb begin
        unused_bits = ^{t_prod[PW-1], t_prod[DATA_WIDTH-1:0],
                        n_prod[2*DATA_WIDTH-1:2*DATA_WIDTH-2], n_prod[DATA_WIDTH-3:0]};
    end

endmodule

// File: rtl/hybrid_chaotic_encryption.sv
// Byte-stream cipher: logistic-map keystream, alpha mask, ciphertext feedback.
// A key load discards k warm-up iterations, then each accepted byte advances the map once.
module hybrid_chaotic_encryption
    import hybrid_chaotic_encryption_pkg::*;
#(
    parameter  int DATA_WIDTH  = 12,
    parameter  int INPUT_WIDTH = 8,
    localparam int KEY_WIDTH   = 4 * INPUT_WIDTH + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [KEY_WIDTH-1:0]   key,
    input  logic                   key_valid_in,
    input  logic [INPUT_WIDTH-1:0] plaintext,
    input  logic                   plaintext_valid_in,
    output logic [INPUT_WIDTH-1:0] ciphertext,
    output logic                   ciphertext_valid
);

    state_t state;
    state_t next_state;

    logic [DATA_WIDTH-1:0]  mu;
    logic [DATA_WIDTH-1:0]  y0;
    logic [INPUT_WIDTH-1:0] alpha;
    logic                   prec;
    logic [DATA_WIDTH-1:0]  x;
    logic [INPUT_WIDTH-1:0] cnt;
    logic [INPUT_WIDTH-1:0] c_prev;

    logic [INPUT_WIDTH-1:0] key_k;
    logic [DATA_WIDTH-1:0]  key_mu;
    logic [DATA_WIDTH-1:0]  key_y0;

    logic                   load;
    logic                   warm_step;
    logic                   accept;

    logic [DATA_WIDTH-1:0]  xn;
    logic [INPUT_WIDTH-1:0] ks;
    logic [INPUT_WIDTH-1:0] c_next;

    // Key field decode into fixed-point map parameters
    always_comb begin
        key_k  = key[KEY_K_LSB +: INPUT_WIDTH];
        key_mu = {MU_INT_PREFIX, key[KEY_MU_LSB +: INPUT_WIDTH], 2'b00};
        key_y0 = {key[KEY_Y0_LSB +: INPUT_WIDTH], Y0_PAD};
    end

    logistic_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_step (
        .x    (x),
        .mu   (mu),
        .prec (prec),
        .fx   (xn)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: a key load overrides everything
    always_comb begin
        next_state = state;
        if (key_valid_in) begin
            next_state = (key_k != '0) ? WARMUP : RUN;
        end else begin
            case (state)
                WARMUP:  if (cnt <= 8'd1) next_state = RUN;
                default: next_state = state;
            endcase
        end
    end

    // Control decode: plaintext is only consumed in RUN when no key is loading
    always_comb begin
        load      = key_valid_in;
        warm_step = !key_valid_in && (state == WARMUP);
        accept    = !key_valid_in && (state == RUN) && plaintext_valid_in;
    end

    // Keystream and feedback cipher byte
    always_comb begin
        ks     = xn[DATA_WIDTH-1 -: INPUT_WIDTH] ^ alpha;
        c_next = plaintext ^ ks ^ c_prev;
    end

    // Key parameter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mu    <= '0;
            y0    <= '0;
            alpha <= '0;
            prec  <= 1'b0;
        end else if (load) begin
            mu    <= key_mu;
            y0    <= key_y0;
            alpha <= key[KEY_ALPHA_LSB +: INPUT_WIDTH];
            prec  <= key[KEY_PREC_BIT];
        end
    end

    // Map state, warm-up counter and feedback byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x      <= '0;
            cnt    <= '0;
            c_prev <= '0;
        end else if (load) begin
            x      <= key_y0;
            cnt    <= key_k;
            c_prev <= '0;
        end else if (warm_step) begin
            x      <= xn;
            cnt    <= cnt - 8'd1;
        end else if (accept) begin
            x      <= xn;
            c_prev <= c_next;
        end
    end

    // Registered ciphertext output with one-cycle valid strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ciphertext       <= '0;
            ciphertext_valid <= 1'b0;
        end else begin
            ciphertext_valid <= accept;
            if (accept) begin
                ciphertext <= c_next;
            end
        end
    end

endmodule

// File: tb/tb_hybrid_chaotic_encryption.sv
// Directed bench for hybrid_chaotic_encryption with a scoreboard queue of expected bytes.
module tb_hybrid_chaotic_encryption;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [32:0] key;
    logic        key_valid_in;
    logic [7:0]  plaintext;
    logic        plaintext_valid_in;
    logic [7:0]  ciphertext;
    logic        ciphertext_valid;

    int checks = 0;
    int fails  = 0;
    logic [7:0] exp_q[$];

    logic [11:0] m_x;
    logic [11:0] m_mu;
    logic [7:0]  m_alpha;
    logic [7:0]  m_cprev;
    logic [7:0]  m_k;
    bit          m_prec;
    logic [7:0]  last_c;

    hybrid_chaotic_encryption #(
        .DATA_WIDTH  (12),
        .INPUT_WIDTH (8)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .key                (key),
        .key_valid_in       (key_valid_in),
        .plaintext          (plaintext),
        .plaintext_valid_in (plaintext_valid_in),
        .ciphertext         (ciphertext),
        .ciphertext_valid   (ciphertext_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] ref_step(input logic [11:0] xv, input logic [11:0] muv, input bit p);
        int unsigned xi, mi, t, n;
        xi = xv;
        mi = muv;
        t  = ((xi * (4096 - xi)) / 4096) % 4096;
        n  = ((mi * t) / 1024) % 4096;
        if (!p) n = n - (n % 16);
        if (n == 0) n = 16;
        return 12'(n);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: inputs already set, outputs sampled on the falling edge
    task automatic cycle(input string tag);
        @(posedge clk);
        @(negedge clk);
        if (exp_q.size() > 0) begin
            chk({tag, " valid"}, 32'(ciphertext_valid), 32'd1);
            chk({tag, " data"}, 32'(ciphertext), 32'(exp_q.pop_front()));
        end else begin
            chk({tag, " valid"}, 32'(ciphertext_valid), 32'd0);
        end
    endtask

    task automatic key_cycle(input logic [32:0] kv, input string tag);
        key                = kv;
        key_valid_in       = 1'b1;
        plaintext_valid_in = 1'b1;
        plaintext          = 8'h3C;
        cycle(tag);
        key_valid_in = 1'b0;
        m_mu    = {2'b11, kv[7:0], 2'b00};
        m_x     = {kv[23:16], 4'b1000};
        m_alpha = kv[15:8];
        m_prec  = kv[32];
        m_k     = kv[31:24];
        m_cprev = 8'h00;
    endtask

    task automatic warmup(input bit check_lsb);
        plaintext_valid_in = 1'b1;
        plaintext          = 8'hAA;
        for (int i = 0; i < int'(m_k); i++) begin
            cycle("warmup");
            m_x = ref_step(m_x, m_mu, m_prec);
            chk("warmup x", 32'(dut.x), 32'(m_x));
            if (check_lsb) chk("warmup x lsb", 32'(dut.x[3:0]), 32'd0);
        end
    endtask

    task automatic send(input logic [7:0] p, input string tag);
        logic [7:0] c;
        plaintext          = p;
        plaintext_valid_in = 1'b1;
        m_x     = ref_step(m_x, m_mu, m_prec);
        c       = p ^ m_x[11:4] ^ m_alpha ^ m_cprev;
        m_cprev = c;
        exp_q.push_back(c);
        cycle(tag);
        chk({tag, " x"}, 32'(dut.x), 32'(m_x));
        last_c = c;
    endtask

    task automatic gap();
        plaintext_valid_in = 1'b0;
        plaintext          = 8'($urandom);
        cycle("gap");
        chk("gap x frozen", 32'(dut.x), 32'(m_x));
        chk("gap data hold", 32'(ciphertext), 32'(last_c));
    endtask

    initial begin
        logic [7:0] prev;

        rst_n = 1'b0; key = '0; key_valid_in = 1'b0;
        plaintext = '0; plaintext_valid_in = 1'b0;
        last_c = '0;
        repeat (2) @(negedge clk);
        chk("reset data", 32'(ciphertext), 32'd0);
        chk("reset valid", 32'(ciphertext_valid), 32'd0);
        chk("reset mu", 32'(dut.mu), 32'd0);
        chk("reset y0", 32'(dut.y0), 32'd0);
        rst_n = 1'b1;

        // Key load with plaintext present on the key edge: byte dropped
        key_cycle({1'b1, 8'h02, 8'h03, 8'h04, 8'h05}, "key1 E0");
        chk("key1 mu", 32'(dut.mu), 32'h0C14);
        chk("key1 y0", 32'(dut.y0), 32'h0038);
        warmup(1'b0);
        chk("key1 x after warmup", 32'(dut.x), 32'h01E0);
        send(8'hAA, "E3");
        chk("E3 data const", 32'(ciphertext), 32'h00E1);

        // Feedback chain
        for (int i = 0; i < 6; i++) begin
            prev = last_c;
            send(8'hAA, "feedback");
            chk("feedback differs", 32'(ciphertext != prev), 32'(last_c != prev));
        end

        // Rekey mid-stream, 8-bit precision
        key_cycle({1'b0, 8'h05, 8'h04, 8'h03, 8'h40}, "rekey");
        chk("rekey mu", 32'(dut.mu), 32'h0D00);
        chk("rekey y0", 32'(dut.y0), 32'h0048);
        chk("rekey c_prev", 32'(dut.c_prev), 32'd0);
        warmup(1'b1);
        for (int i = 0; i < 3; i++) begin
            send(8'(8'h10 + i), "rekey run");
            chk("run x lsb", 32'(dut.x[3:0]), 32'd0);
        end

        // k = 0: RUN immediately, then gaps in plaintext
        key_cycle({1'b1, 8'h00, 8'hA7, 8'h3C, 8'h81}, "k0 key");
        send(8'h11, "k0 first");
        gap();
        send(8'h22, "k0 b2");
        gap();
        gap();
        send(8'h33, "k0 b3");
        send(8'h44, "k0 b4");

        // Holding key_valid_in restarts warm-up every cycle
        key_cycle({1'b1, 8'h02, 8'h03, 8'h04, 8'h05}, "hold1");
        key_cycle({1'b1, 8'h02, 8'h03, 8'h04, 8'h05}, "hold2");
        key_cycle({1'b1, 8'h02, 8'h03, 8'h04, 8'h05}, "hold3");
        chk("hold cnt", 32'(dut.cnt), 32'd2);
        warmup(1'b0);
        send(8'hAA, "hold run");
        chk("hold data const", 32'(ciphertext), 32'h00E1);

        // Asynchronous reset mid-operation
        plaintext_valid_in = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst data", 32'(ciphertext), 32'd0);
        chk("async rst valid", 32'(ciphertext_valid), 32'd0);
        chk("async rst x", 32'(dut.x), 32'd0);
        chk("async rst mu", 32'(dut.mu), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/hybrid_chaotic_encryption.md
# hybrid_chaotic_encryption

Byte-stream cipher built on a fixed-point logistic chaotic map with alpha masking and ciphertext feedback. A 33-bit key loads the map parameters and initial state, and k warm-up iterations are discarded. After warm-up, each accepted plaintext byte advances the map one step and produces one ciphertext byte. The block sits in the crypto datapath between the plaintext source and the downstream ciphertext consumer, with no backpressure.

## Interface
- DATA_WIDTH, 12, fixed-point width of map state and internal mu/y0. Only 12 is supported.
- INPUT_WIDTH, 8, plaintext/ciphertext width. Only 8 is supported.
- KEY_WIDTH (localparam), 4*INPUT_WIDTH+1 = 33, key width.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- key  in  33  key fields:
  - [32] precision_sel: 1 = 12-bit, 0 = 8-bit.
  - [31:24] k (warm-up count); [23:16] y0_8; [15:8] alpha; [7:0] mu_8.
- key_valid_in  in  1  load key this cycle.
- plaintext  in  8  data byte.
- plaintext_valid_in  in  1  plaintext present this cycle.
- ciphertext  out  8  encrypted byte (registered).
- ciphertext_valid  out  1  one-cycle strobe qualifying ciphertext.

## Operation
- Internal registers:
  - mu (12b, Q2.10) = {2'b11, mu_8, 2'b00}, i.e. 3 + mu_8/256.
  - y0 (12b, Q0.12) = {y0_8, 4'b1000}; never zero.
  - alpha, prec, x (map state), cnt (8b), c_prev (8b).
- Map step f(x):
  - t = (x * (4096 − x)) >> 12, truncated to 12b.
  - n = (mu * t) >> 10, low 12 bits.
  - If prec = 0, n[3:0] = 0.
  - If n = 0, n = 12'h010.
- States: IDLE, WARMUP, RUN.
- key_valid_in = 1 (any state, highest priority):
  - Latch all key fields; x <= y0; c_prev <= 0; cnt <= k.
  - Next state: WARMUP if k ≠ 0, else RUN.
  - A plaintext presented in the same cycle is dropped.
- WARMUP: each cycle x <= f(x), cnt <= cnt − 1. When cnt = 1, go to RUN. Exactly k iterations run.
- RUN with plaintext_valid_in = 1:
  - xn = f(x); x <= xn.
  - ks = xn[11:4] ^ alpha.
  - c = plaintext ^ ks ^ c_prev.
  - ciphertext <= c; c_prev <= c; ciphertext_valid <= 1.
- RUN with no plaintext: x holds, ciphertext_valid <= 0, ciphertext holds its last value.
- IDLE and WARMUP: plaintext is ignored and ciphertext_valid = 0.
- Holding key_valid_in high reloads on every cycle, so warm-up restarts.

## Timing
- Reset values: ciphertext = 0, ciphertext_valid = 0, state = IDLE, mu = y0 = x = alpha = cnt = c_prev = 0, prec = 0.
- mu and y0 are visible the cycle after the key edge.
- Warm-up takes k cycles after the key edge.
- Latency: plaintext sampled at edge N gives ciphertext/valid at edge N (visible before edge N+1). Throughput is 1 byte/cycle.
- Reset assertion mid-operation clears everything immediately; a key must be reloaded afterwards.

## Structure
- Shared package contents:
  - State enum.
  - Key field bit positions.
  - MU_INT_PREFIX = 2'b11, Y0_PAD = 4'b1000, ZERO_FIX = 12'h010.
- One combinational sub-module, logistic_step: inputs x, mu, prec; output f(x). Instantiated once in the top.
- The top holds the key registers, the FSM/counter and the cipher datapath.

## Test plan
- Reset: hold rst_n = 0 → ciphertext = 0, ciphertext_valid = 0, mu = 0, y0 = 0.
- Key load, state and parameters: key = {1, 8'h02, 8'h03, 8'h04, 8'h05} with plaintext_valid_in = 1 and key_valid_in pulsed one cycle, key edge E0:
  - Next cycle: mu = 12'hC14, y0 = 12'h038.
  - After 2 warm-up cycles: x = 12'h1E0.
  - At E3: ciphertext = 8'hE1, valid = 1.
- Key load, plaintext dropped: on the E0 edge of the same scenario, ciphertext_valid stays 0.
- Feedback: continue plaintext = 8'hAA → each new byte uses c_prev. Check against a reference model; consecutive outputs differ.
- Rekey mid-stream: key = {0, 8'h05, 8'h04, 8'h03, 8'h40} →
  - mu = 12'hD00, y0 = 12'h048.
  - c_prev cleared; no valid output for 5 cycles.
  - Every x has x[3:0] = 0.
- k = 0 and gaps: key with k = 0 → RUN directly, and the first plaintext is encrypted on the next edge. Toggling plaintext_valid_in → valid only on accepted cycles, and x is frozen during gaps.
